// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external ALU between two requesters, with extra hold cycles for FP ops
module alu_arbiter #(
    parameter int FP_HOLD = 1
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        req0_valid_i,
    input  logic        req1_valid_i,
    output logic        req0_ready_o,
    output logic        req1_ready_o,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    input  logic [4:0]  req0_op_i,
    input  logic [4:0]  req1_op_i,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [4:0]  alu_op_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i,
    input  logic        alu_set_i,
    input  logic        alu_carry_i,
    input  logic        alu_ovf_i,
    output logic        rsp0_valid_o,
    output logic        rsp1_valid_o,
    output logic [31:0] rsp_result_o,
    output logic        rsp_zero_o,
    output logic        rsp_set_o,
    output logic        rsp_carry_o,
    output logic        rsp_ovf_o,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE, EXEC, FPWAIT} state_t;
    localparam logic [3:0] HOLD = 4'(FP_HOLD);
    state_t      state_q;
    logic        rr_q;
    logic        owner_q;
    logic [3:0]  cnt_q;
    logic [31:0] alu_a_q;
    logic [31:0] alu_b_q;
    logic [4:0]  alu_op_q;
    logic [31:0] rsp_result_q;
    logic [3:0]  rsp_flags_q;
    logic        rsp0_valid_q;
    logic        rsp1_valid_q;
    logic        grant1;
    logic        fp_op;
    logic        capture;
    // Grant decision, handshake and the cycle in which the ALU result is taken
    always_comb begin
        grant1       = req1_valid_i && (!req0_valid_i || rr_q);
        req0_ready_o = (state_q == IDLE) && req0_valid_i && !grant1;
        req1_ready_o = (state_q == IDLE) && grant1;
        fp_op        = (alu_op_q == 5'b01111) || (alu_op_q == 5'b11110) || (alu_op_q == 5'b11111);
        capture      = ((state_q == EXEC) && !(fp_op && (HOLD != 4'd0))) ||
                       ((state_q == FPWAIT) && (cnt_q == 4'd1));
    end
    // Control FSM with operand latch, hold counter and response capture
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            owner_q      <= 1'b0;
            cnt_q        <= 4'd0;
            alu_a_q      <= 32'd0;
            alu_b_q      <= 32'd0;
            alu_op_q     <= 5'b00000;
            rsp_result_q <= 32'd0;
            rsp_flags_q  <= 4'd0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            rsp0_valid_q <= capture && !owner_q;
            rsp1_valid_q <= capture && owner_q;
            if (capture) begin
                rsp_result_q <= alu_result_i;
                rsp_flags_q  <= {alu_zero_i, alu_set_i, alu_carry_i, alu_ovf_i};
            end
            case (state_q)
                IDLE: begin
                    if (req0_ready_o || req1_ready_o) begin
                        alu_a_q  <= grant1 ? req1_a_i : req0_a_i;
                        alu_b_q  <= grant1 ? req1_b_i : req0_b_i;
                        alu_op_q <= grant1 ? req1_op_i : req0_op_i;
                        owner_q  <= grant1;
                        rr_q     <= !grant1;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    cnt_q   <= capture ? 4'd0 : HOLD;
                    state_q <= capture ? IDLE : FPWAIT;
                end
                FPWAIT: begin
                    cnt_q   <= cnt_q - 4'd1;
                    state_q <= capture ? IDLE : FPWAIT;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_op_o     = alu_op_q;
    assign rsp0_valid_o = rsp0_valid_q;
    assign rsp1_valid_o = rsp1_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_zero_o   = rsp_flags_q[3];
    assign rsp_set_o    = rsp_flags_q[2];
    assign rsp_carry_o  = rsp_flags_q[1];
    assign rsp_ovf_o    = rsp_flags_q[0];
    assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural shared ALU
module tb_alu_arbiter;
    localparam logic [4:0] ADD  = 5'b00010;
    localparam logic [4:0] SUB  = 5'b00011;
    localparam logic [4:0] ITOF = 5'b11110;
    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        int          cyc;
    } exp_t;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [4:0]  req0_op = 0, req1_op = 0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [4:0]  alu_op;
    logic        alu_zero, alu_set, alu_carry, alu_ovf;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_set, rsp_carry, rsp_ovf;
    logic        busy;
    logic [32:0] sum;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    int          gl[$];
    exp_t        me;

    alu_arbiter #(.FP_HOLD(3)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .req0_valid_i(req0_valid), .req1_valid_i(req1_valid),
        .req0_ready_o(req0_ready), .req1_ready_o(req1_ready),
        .req0_a_i(req0_a), .req0_b_i(req0_b), .req1_a_i(req1_a), .req1_b_i(req1_b),
        .req0_op_i(req0_op), .req1_op_i(req1_op),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .alu_result_i(alu_result), .alu_zero_i(alu_zero), .alu_set_i(alu_set),
        .alu_carry_i(alu_carry), .alu_ovf_i(alu_ovf),
        .rsp0_valid_o(rsp0_valid), .rsp1_valid_o(rsp1_valid),
        .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .rsp_set_o(rsp_set),
        .rsp_carry_o(rsp_carry), .rsp_ovf_o(rsp_ovf), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] itof(input logic [31:0] a);
        int p = 0;
        logic [31:0] m;
        if (a == 32'd0) return 32'd0;
        for (int i = 0; i < 32; i++) if (a[i]) p = i;
        m = (p > 23) ? (a >> (p - 23)) : (a << (23 - p));
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    // Behavioural shared ALU: add, subtract (carry = borrow), int-to-float, FP pass-through, xor otherwise
    always_comb begin
        sum        = 33'd0;
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        alu_result = alu_a ^ alu_b;
        case (alu_op)
            ADD: begin
                sum        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = sum[31:0];
                alu_carry  = sum[32];
                alu_ovf    = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            end
            SUB: begin
                alu_result = alu_a - alu_b;
                alu_carry  = alu_a < alu_b;
                alu_ovf    = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            ITOF: alu_result = itof(alu_a);
            5'b01111, 5'b11111: alu_result = alu_a;
            default: ;
        endcase
        alu_zero = (alu_result == 32'd0);
        alu_set  = alu_result[31];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset();
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_flags", 32'({rsp_zero, rsp_set, rsp_carry, rsp_ovf}), 32'd0);
        chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
    endtask

    task automatic chk_grants(input int n, input logic [7:0] pat);
        chk("grant_count", 32'(gl.size()), 32'(n));
        for (int i = 0; i < n && i < gl.size(); i++) chk("grant_order", 32'(gl[i]), 32'(pat[i]));
    endtask

    task automatic drive(input bit p, input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                         input logic [31:0] r, input logic [3:0] f, input int lat, input bit expect_rsp);
        exp_t e;
        bit done = 0;
        @(negedge clk);
        if (p) begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (p ? req1_ready : req0_ready) begin
                done  = 1;
                e.r   = r;
                e.f   = f;
                e.cyc = cyc + lat;
                if (expect_rsp) begin
                    if (p) q1.push_back(e);
                    else q0.push_back(e);
                end
            end else begin
                @(negedge clk);
                #1;
            end
        end
        chk($sformatf("grant_req%0d", p), 32'(done), 32'd1);
        @(posedge clk);
        #1;
        if (p) begin
            req1_valid = 0; req1_a = ~a; req1_b = 32'h5A5A5A5A; req1_op = 5'b10101;
        end else begin
            req0_valid = 0; req0_a = ~a; req0_b = 32'hA5A5A5A5; req0_op = 5'b10101;
        end
    endtask

    // Monitor: exclusive-ready check, grant log, and scoreboard compare on each response pulse
    always @(negedge clk) begin
        #2;
        chk("both_ready", 32'(req0_ready && req1_ready), 32'd0);
        if (req0_ready && req0_valid) gl.push_back(0);
        if (req1_ready && req1_valid) gl.push_back(1);
        if (rsp0_valid) begin
            if (q0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
            else begin
                me = q0.pop_front();
                chk("rsp0_result", rsp_result, me.r);
                chk("rsp0_flags", 32'({rsp_zero, rsp_set, rsp_carry, rsp_ovf}), 32'(me.f));
                chk("rsp0_cycle", 32'(cyc), 32'(me.cyc));
            end
        end
        if (rsp1_valid) begin
            if (q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
            else begin
                me = q1.pop_front();
                chk("rsp1_result", rsp_result, me.r);
                chk("rsp1_flags", 32'({rsp_zero, rsp_set, rsp_carry, rsp_ovf}), 32'(me.f));
                chk("rsp1_cycle", 32'(cyc), 32'(me.cyc));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check_reset();
        @(posedge clk);
        #1;
        reset_n = 1;
        gl.delete();
        fork
            drive(0, 32'd5, 32'd7, ADD, 32'd12, 4'b0000, 2, 1);
            drive(1, 32'd9, 32'd4, SUB, 32'd5, 4'b0000, 2, 1);
        join
        chk_grants(2, 8'b00000010);
        drive(1, 32'h10, 32'h10, SUB, 32'd0, 4'b1000, 2, 1);
        drive(0, 32'd1, 32'd0, ITOF, 32'h3F800000, 4'b0000, 5, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            chk("fp_busy_high", 32'(busy), 32'd1);
        end
        @(negedge clk);
        #2;
        chk("fp_busy_low", 32'(busy), 32'd0);
        drive(1, 32'hCAFE0001, 32'd0, 5'b01111, 32'hCAFE0001, 4'b0100, 5, 1);
        drive(0, 32'h12345678, 32'd0, 5'b11111, 32'h12345678, 4'b0000, 5, 1);
        drive(0, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'b10101, 32'hFFFFFFFF, 4'b0100, 2, 1);
        drive(1, 32'h7FFFFFFF, 32'd1, ADD, 32'h80000000, 4'b0101, 2, 1);
        drive(0, 32'hFFFFFFFF, 32'd1, ADD, 32'd0, 4'b1010, 2, 1);
        drive(0, 32'd3, 32'd0, ITOF, 32'd0, 4'b0000, 5, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 0;
        @(negedge clk);
        #2;
        check_reset();
        reset_n = 1;
        repeat (8) @(negedge clk);
        gl.delete();
        fork
            drive(0, 32'd40, 32'd2, ADD, 32'd42, 4'b0000, 2, 1);
            drive(1, 32'd50, 32'd8, SUB, 32'd42, 4'b0000, 2, 1);
        join
        chk_grants(2, 8'b00000010);
        gl.delete();
        fork
            begin
                drive(0, 32'd1, 32'd2, ADD, 32'd3, 4'b0000, 2, 1);
                drive(0, 32'd10, 32'd3, SUB, 32'd7, 4'b0000, 2, 1);
                drive(0, 32'd100, 32'd200, ADD, 32'd300, 4'b0000, 2, 1);
                drive(0, 32'd0, 32'd1, SUB, 32'hFFFFFFFF, 4'b0110, 2, 1);
            end
            begin
                drive(1, 32'd3, 32'd3, SUB, 32'd0, 4'b1000, 2, 1);
                drive(1, 32'h80000000, 32'h80000000, ADD, 32'd0, 4'b1011, 2, 1);
                drive(1, 32'd7, 32'd8, ADD, 32'd15, 4'b0000, 2, 1);
                drive(1, 32'd20, 32'd5, SUB, 32'd15, 4'b0000, 2, 1);
            end
        join
        chk_grants(8, 8'b10101010);
        for (int i = 0; i < 20 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
